assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache_if.sv | 32 +++
 rtl/assoc_cache.sv | 191 +++++++++++++++++++
 tb/tb_assoc_cache.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side bus bundle for assoc_cache.
// master = CPU plus physical-memory environment; slave = the cache.
interface assoc_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable_cpu;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata_cpu;
    logic         mem_resp;
    logic [31:0]  mem_rdata_cpu;

    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;

    modport master (
        output mem_read, mem_write, mem_byte_enable_cpu, mem_address, mem_wdata_cpu,
        input  mem_resp, mem_rdata_cpu,
        output pmem_resp, pmem_rdata,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable_cpu, mem_address, mem_wdata_cpu,
        output mem_resp, mem_rdata_cpu,
        input  pmem_resp, pmem_rdata,
        output pmem_address, pmem_wdata, pmem_read, pmem_write
    );
endinterface

// File: rtl/assoc_cache.sv
// Set-associative write-back cache, 256-bit lines, tree pseudo-LRU replacement.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a CPU read or write request
// CHECK     | tag lookup; hit -> respond, miss -> pick victim
// WRITEBACK | dirty victim line being written to memory
// FILL      | requested line being read from memory into the victim way
module assoc_cache #(
    parameter int S_INDEX = 3,
    parameter int N_WAYS  = 2
) (
    input  logic clk,
    input  logic rst_n,
    assoc_cache_if.slave bus
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;
    localparam int WAY_W = (N_WAYS == 4) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N_WAYS-1:0] valid_arr [SETS];
    logic [N_WAYS-1:0] dirty_arr [SETS];
    logic [2:0]        plru_arr  [SETS];
    logic [TAG_W-1:0]  tag_arr   [SETS][N_WAYS];
    logic [255:0]      data_arr  [SETS][N_WAYS];

    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic               unused_addr_bits;

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_d, victim_q;
    logic               victim_dirty;
    logic [255:0]       hit_line, merged_line;
    logic [2:0]         plru_touched;

    assign idx              = bus.mem_address[5+S_INDEX-1:5];
    assign tag              = bus.mem_address[31:5+S_INDEX];
    assign word             = bus.mem_address[4:2];
    assign unused_addr_bits = ^bus.mem_address[1:0];

    // Tree bits point toward the least-recently-used side:
    // [0] root (0: ways 0/1, 1: ways 2/3), [1] within 0/1, [2] within 2/3.
    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        logic [1:0] v;
        v = 2'd0;
        if (N_WAYS == 2)
            v = {1'b0, p[0]};
        else if (N_WAYS == 4)
            v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
        return v;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n = p;
        if (N_WAYS == 2) begin
            n[0] = ~w[0];
        end else if (N_WAYS == 4) begin
            n[0] = ~w[1];
            if (w[1]) n[2] = ~w[0];
            else      n[1] = ~w[0];
        end
        return n;
    endfunction

    // Tag lookup in the addressed set and write-data merge into the hitting line.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_arr[idx][w] && (tag_arr[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_line    = data_arr[idx][hit_way];
        merged_line = hit_line;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_byte_enable_cpu[i])
                merged_line[32*int'(word) + 8*i +: 8] = bus.mem_wdata_cpu[8*i +: 8];
        end
        plru_touched = plru_touch(plru_arr[idx], 2'(hit_way));
    end

    // Victim choice: lowest invalid way wins, otherwise the pseudo-LRU way.
    always_comb begin
        victim_d = WAY_W'(plru_victim(plru_arr[idx]));
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[idx][w]) victim_d = WAY_W'(w);
        end
        victim_dirty = valid_arr[idx][victim_d] && dirty_arr[idx][victim_d];
    end

    // Next-state and output decode; all outputs forced low while reset is held.
    always_comb begin
        state_d           = state_q;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata_cpu = '0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_address  = '0;
        bus.pmem_wdata    = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) state_d = CHECK;
                end
                CHECK: begin
                    if (hit) begin
                        bus.mem_resp      = 1'b1;
                        bus.mem_rdata_cpu = hit_line[32*int'(word) +: 32];
                        state_d           = IDLE;
                    end else begin
                        state_d = victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write   = 1'b1;
                    bus.pmem_address = {tag_arr[idx][victim_q], idx, 5'b0};
                    bus.pmem_wdata   = data_arr[idx][victim_q];
                    if (bus.pmem_resp) state_d = FILL;
                end
                FILL: begin
                    bus.pmem_read    = 1'b1;
                    bus.pmem_address = {bus.mem_address[31:5], 5'b0};
                    if (bus.pmem_resp) state_d = CHECK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register plus valid/dirty/replacement bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                CHECK: begin
                    if (hit) begin
                        plru_arr[idx] <= plru_touched;
                        if (bus.mem_write) dirty_arr[idx][hit_way] <= 1'b1;
                    end else begin
                        victim_q <= victim_d;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) dirty_arr[idx][victim_q] <= 1'b0;
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid_arr[idx][victim_q] <= 1'b1;
                        dirty_arr[idx][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tags; contents are meaningless until the way is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == FILL && bus.pmem_resp) begin
                data_arr[idx][victim_q] <= bus.pmem_rdata;
                tag_arr[idx][victim_q]  <= tag;
            end else if (state_q == CHECK && hit && bus.mem_write) begin
                data_arr[idx][hit_way] <= merged_line;
            end
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (S_INDEX=3, N_WAYS=2) acting as CPU and memory.
module tb_assoc_cache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    assoc_cache_if bus();

    assoc_cache #(.S_INDEX(3), .N_WAYS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // per-operation memory traffic log
    int           n_rd, n_wr, lat;
    logic         wb_first, both_hi, done;
    logic [31:0]  rd_addr, wr_addr, rdata;
    logic [255:0] wr_data, exp_line;

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = 32'hA000_0000 | a | k;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one CPU request (called at a negedge) and serve memory with 3-cycle latency.
    task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
        int busy;
        n_rd = 0; n_wr = 0; wb_first = 1'b0; done = 1'b0; lat = 0; busy = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = '0;
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
        bus.mem_wdata_cpu = wd; bus.mem_byte_enable_cpu = be;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) both_hi = 1'b1;
            if (bus.mem_resp) begin
                rdata = bus.mem_rdata_cpu;
                lat   = c + 2;
                done  = 1'b1;
            end else if (bus.pmem_read || bus.pmem_write) begin
                busy++;
                if (busy == 3) begin
                    busy = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        n_wr++;
                        wr_addr = bus.pmem_address;
                        wr_data = bus.pmem_wdata;
                        if (n_rd == 0) wb_first = 1'b1;
                    end else begin
                        n_rd++;
                        rd_addr = bus.pmem_address;
                        bus.pmem_rdata = pat(bus.pmem_address);
                    end
                end
            end
        end
        chk("completed", done, 1'b1);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        chk("resp_single_cycle", bus.mem_resp, 1'b0);
    endtask

    initial begin
        both_hi = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable_cpu = '0;
        bus.mem_address = '0; bus.mem_wdata_cpu = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_resp", bus.mem_resp, 1'b0);
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_pmem_address", bus.pmem_address, 32'h0);
        chk("idle_pmem_wdata", bus.pmem_wdata, 256'h0);
        chk("idle_rdata", bus.mem_rdata_cpu, 32'h0);

        // cold read miss
        op(1, 0, 32'h40, 0, 4'h0);
        chk("cold_lat", lat, 6);
        chk("cold_n_rd", n_rd, 1);
        chk("cold_n_wr", n_wr, 0);
        chk("cold_rd_addr", rd_addr, 32'h40);
        chk("cold_rdata", rdata, 32'hA000_0040);

        // masked write hit then read back
        op(0, 1, 32'h44, 32'hDEAD_BEEF, 4'b0101);
        chk("wr_hit_lat", lat, 2);
        chk("wr_hit_pmem", n_rd + n_wr, 0);
        op(1, 0, 32'h44, 0, 4'h0);
        chk("rd_merge_lat", lat, 2);
        chk("rd_merge_pmem", n_rd + n_wr, 0);
        chk("rd_merge_data", rdata, 32'hA0AD_00EF);
        op(1, 0, 32'h40, 0, 4'h0);
        chk("rd_w0_data", rdata, 32'hA000_0040);

        // LRU in set 0: A=0x000, B=0x100, C=0x200
        op(1, 0, 32'h000, 0, 4'h0);
        chk("A_fill_lat", lat, 6);
        chk("A_rdata", rdata, 32'hA000_0000);
        op(1, 0, 32'h100, 0, 4'h0);
        chk("B_fill_lat", lat, 6);
        chk("B_rdata", rdata, 32'hA000_0100);
        op(1, 0, 32'h000, 0, 4'h0);
        chk("A_hit_lat", lat, 2);
        op(1, 0, 32'h200, 0, 4'h0);
        chk("C_miss_lat", lat, 6);
        chk("C_no_wb", n_wr, 0);
        chk("C_rdata", rdata, 32'hA000_0200);
        op(1, 0, 32'h000, 0, 4'h0);
        chk("A_still_hit", lat, 2);
        op(1, 0, 32'h100, 0, 4'h0);
        chk("B_was_evicted", lat, 6);

        // dirty eviction in set 1: D=0x020, E=0x120, F=0x220
        op(0, 1, 32'h020, 32'h1234_5678, 4'hF);
        chk("D_wr_miss_lat", lat, 6);
        chk("D_wr_miss_rd", n_rd, 1);
        op(1, 0, 32'h120, 0, 4'h0);
        chk("E_fill_lat", lat, 6);
        op(1, 0, 32'h220, 0, 4'h0);
        exp_line = pat(32'h020);
        exp_line[31:0] = 32'h1234_5678;
        chk("F_wb_lat", lat, 9);
        chk("F_n_wr", n_wr, 1);
        chk("F_wb_first", wb_first, 1'b1);
        chk("F_wb_addr", wr_addr, 32'h020);
        chk("F_wb_data", wr_data, exp_line);
        chk("F_rd_addr", rd_addr, 32'h220);
        chk("F_rdata", rdata, 32'hA000_0220);

        // read and write together act as a write
        op(1, 1, 32'h224, 32'hCAFE_F00D, 4'hF);
        chk("rw_lat", lat, 2);
        chk("rw_pmem", n_rd + n_wr, 0);
        op(1, 0, 32'h224, 0, 4'h0);
        chk("rw_readback", rdata, 32'hCAFE_F00D);
        op(1, 0, 32'h020, 0, 4'h0);
        chk("D_refill_clean", n_wr, 0);
        op(1, 0, 32'h120, 0, 4'h0);
        exp_line = pat(32'h220);
        exp_line[63:32] = 32'hCAFE_F00D;
        chk("rw_dirty_wb_lat", lat, 9);
        chk("rw_wb_addr", wr_addr, 32'h220);
        chk("rw_wb_data", wr_data, exp_line);

        // reset in the middle of a fill
        bus.mem_read = 1'b1; bus.mem_address = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("fill_started", bus.pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("pmem_read_in_rst", bus.pmem_read, 1'b0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        chk("after_rst_pmem_read", bus.pmem_read, 1'b0);
        chk("after_rst_pmem_addr", bus.pmem_address, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        op(1, 0, 32'h300, 0, 4'h0);
        chk("abandoned_refetch_lat", lat, 6);
        chk("abandoned_refetch_rd", n_rd, 1);
        op(1, 0, 32'h000, 0, 4'h0);
        chk("rst_cleared_valid", lat, 6);

        chk("never_both_pmem", both_hi, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
